// File: rtl/i2s_slave_rx_pkg.sv
// Shared constants and types for the I2S slave receiver.
// The clock divider uses the same constants, so both agree on the 64fs frame timing.
package i2s_slave_rx_pkg;

  localparam int SYS_CLK_HZ      = 49_152_000;
  localparam int SAMPLE_RATE_HZ  = 48_000;
  localparam int DATA_W_DEF      = 24;
  localparam int SLOT_W_DEF      = 32;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int LOCK_FRAMES_DEF = 4;
  localparam int TIMEOUT_DEF     = 1024;

  // System clocks per BCLK at the nominal sample rate (two slots per frame).
  localparam int BCLK_DIV_NOM = SYS_CLK_HZ / (SAMPLE_RATE_HZ * 2 * SLOT_W_DEF);

  typedef enum logic {
    RX_UNLOCKED = 1'b0,
    RX_LOCKED   = 1'b1
  } rx_state_t;

endpackage

// File: rtl/i2s_sync_edge.sv
// N-stage synchroniser for one asynchronous I2S pin.
// It also gives a one-cycle rise pulse, taken from the last stage and its delayed copy.
module i2s_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/i2s_slave_rx.sv
// Slave-mode I2S receiver: recovers slot timing from an external BCLK/LRCK master.
// It delivers stereo words with a strobe once frame timing has been verified.
module i2s_slave_rx
  import i2s_slave_rx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SLOT_W      = SLOT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2s_bclk,
  input  logic              i2s_lrck,
  input  logic              i2s_sdata,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              sample_valid,
  output logic              locked,
  output logic              frame_err
);

  localparam int CNT_W  = $clog2(SLOT_W);
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W);
  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_FRAMES);
  localparam logic [TO_W-1:0]   TO_HIT    = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT);

  logic bclk_rise, bclk_level_unused;
  logic lrck_s, lrck_rise_unused;
  logic sdata_s, sdata_rise_unused;

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_bclk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (i2s_bclk),
    .level (bclk_level_unused),
    .rise  (bclk_rise)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_lrck (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (i2s_lrck),
    .level (lrck_s),
    .rise  (lrck_rise_unused)
  );

  i2s_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (i2s_sdata),
    .level (sdata_s),
    .rise  (sdata_rise_unused)
  );

  logic [CNT_W-1:0]  bit_cnt, bit_nxt;
  logic              slot_over;
  logic              aligned;
  logic              left_good;
  logic              lrck_prev;
  logic              frame_pend;
  logic [DATA_W-1:0] shift_q, left_hold, right_hold;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [TO_W-1:0]   to_cnt;
  rx_state_t         state;

  logic boundary, slot_ok, slot_err, timeout_hit, err;

  always_comb begin
    boundary    = bclk_rise && (lrck_s != lrck_prev);
    slot_ok     = (bit_cnt == SLOT_LAST) && !slot_over;
    slot_err    = boundary && aligned && !slot_ok;
    timeout_hit = !bclk_rise && (to_cnt == TO_HIT);
    err         = slot_err || timeout_hit;
    bit_nxt     = (bit_cnt == SLOT_LAST) ? bit_cnt : bit_cnt + CNT_W'(1);
    good_nxt    = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GOOD_W'(1);
  end

  // The counter parks at TIMEOUT after firing, so a stalled BCLK raises only one error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (bclk_rise) begin
      to_cnt <= '0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Slot tracking runs on BCLK rises. Frame completion is acted on one cycle later, from the hold regs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt      <= '0;
      slot_over    <= 1'b0;
      aligned      <= 1'b0;
      left_good    <= 1'b0;
      lrck_prev    <= 1'b0;
      frame_pend   <= 1'b0;
      shift_q      <= '0;
      left_hold    <= '0;
      right_hold   <= '0;
      good_cnt     <= '0;
      state        <= RX_UNLOCKED;
      left_data    <= '0;
      right_data   <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      frame_pend   <= 1'b0;

      if (bclk_rise) begin
        lrck_prev <= lrck_s;
        if (boundary) begin
          bit_cnt   <= '0;
          slot_over <= 1'b0;
          aligned   <= 1'b1;
          if (aligned && slot_ok) begin
            if (lrck_prev) begin
              right_hold <= shift_q;
              frame_pend <= left_good;
              left_good  <= 1'b0;
            end else begin
              left_hold <= shift_q;
              left_good <= 1'b1;
            end
          end
        end else begin
          if (bit_cnt == SLOT_LAST) begin
            slot_over <= 1'b1;
          end
          bit_cnt <= bit_nxt;
          if (bit_nxt <= DATA_LAST) begin
            shift_q <= {shift_q[DATA_W-2:0], sdata_s};
          end
        end
      end

      if (frame_pend) begin
        good_cnt <= good_nxt;
        if (good_nxt == GOOD_MAX) begin
          state <= RX_LOCKED;
        end
        if (state == RX_LOCKED || good_nxt == GOOD_MAX) begin
          left_data    <= left_hold;
          right_data   <= right_hold;
          sample_valid <= 1'b1;
        end
      end

      // An error overrides everything above and forces realignment on the next boundary.
      if (err) begin
        frame_err  <= 1'b1;
        state      <= RX_UNLOCKED;
        good_cnt   <= '0;
        aligned    <= 1'b0;
        left_good  <= 1'b0;
        frame_pend <= 1'b0;
        if (frame_pend) begin
          sample_valid <= 1'b0;
          left_data    <= left_data;
          right_data   <= right_data;
        end
      end
    end
  end

  assign locked = (state == RX_LOCKED);

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: the bench acts as an external I2S master.
// It checks lock, data, latency, error and timeout behaviour against hand-computed values.
`timescale 1ns/1ps
module tb_i2s_slave_rx;

  localparam int DATA_W      = 24;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i2s_bclk = 1'b0;
  logic              i2s_lrck = 1'b0;
  logic              i2s_sdata = 1'b0;
  logic [DATA_W-1:0] left_data, right_data;
  logic              sample_valid, locked, frame_err;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_valid_cyc = 0;
  int last_err_cyc = 0;
  int last_rise_cyc = 0;
  int left_rise_cyc = 0;
  int half_lo = 160;
  int half_hi = 160;
  int jitter = 0;
  logic last_bit = 1'b0;

  i2s_slave_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrck     (i2s_lrck),
    .i2s_sdata    (i2s_sdata),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .locked       (locked),
    .frame_err    (frame_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc_cnt++;

  // Outputs are observed on the falling clock edge, away from the register updates.
  always @(negedge clk) begin
    if (sample_valid) begin
      valid_cnt++;
      last_valid_cyc = cyc_cnt;
    end
    if (frame_err) begin
      err_cnt++;
      last_err_cyc = cyc_cnt;
    end
  end

  // One slot of nper BCLKs. The first bit carries the previous slot's LSB (I2S one-bit delay).
  task automatic send_slot(input logic lr, input logic [DATA_W-1:0] w, input logic pad, input int nper);
    for (int k = 0; k < nper; k++) begin
      i2s_bclk = 1'b0;
      i2s_lrck = lr;
      if (k == 0) i2s_sdata = last_bit;
      else if (k <= DATA_W) i2s_sdata = w[DATA_W-k];
      else i2s_sdata = pad;
      #(half_lo);
      i2s_bclk = 1'b1;
      last_rise_cyc = cyc_cnt;
      if (k == 0 && lr == 1'b0) left_rise_cyc = cyc_cnt;
      #(half_hi + int'($urandom_range(0, jitter)));
    end
    if (nper - 1 >= 1 && nper - 1 <= DATA_W) last_bit = w[DATA_W-(nper-1)];
    else last_bit = pad;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input logic pad);
    send_slot(1'b0, l, pad, 32);
    send_slot(1'b1, r, pad, 32);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (left_data !== 24'h0) begin failures++; $display("[TB] FAIL reset_left got=%h exp=%h", left_data, 24'h0); end
    checks++; if (right_data !== 24'h0) begin failures++; $display("[TB] FAIL reset_right got=%h exp=%h", right_data, 24'h0); end
    checks++; if (sample_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", sample_valid); end
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL reset_locked got=%b exp=0", locked); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", frame_err); end
    rst_n = 1'b1;
    #3;
  endtask

  task automatic test_nominal();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(24'h123456, 24'hABCDEF, 1'b0);
    repeat (4) send_frame(24'h123456, 24'hABCDEF, 1'b0);
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL nom_locked_early got=%b exp=0", locked); end
    checks++; if (valid_cnt - v0 != 0) begin failures++; $display("[TB] FAIL nom_valid_early got=%0d exp=0", valid_cnt - v0); end
    send_frame(24'h123456, 24'hABCDEF, 1'b0);
    checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL nom_locked got=%b exp=1", locked); end
    checks++; if (valid_cnt - v0 != 1) begin failures++; $display("[TB] FAIL nom_valid_first got=%0d exp=1", valid_cnt - v0); end
    checks++; if (left_data !== 24'h123456) begin failures++; $display("[TB] FAIL nom_left got=%h exp=123456", left_data); end
    checks++; if (right_data !== 24'hABCDEF) begin failures++; $display("[TB] FAIL nom_right got=%h exp=abcdef", right_data); end
    checks++; if (last_valid_cyc - left_rise_cyc != SYNC_STAGES + 2) begin
      failures++; $display("[TB] FAIL nom_latency got=%0d exp=%0d", last_valid_cyc - left_rise_cyc, SYNC_STAGES + 2);
    end
    repeat (3) send_frame(24'h123456, 24'hABCDEF, 1'b0);
    checks++; if (valid_cnt - v0 != 4) begin failures++; $display("[TB] FAIL nom_valid_rate got=%0d exp=4", valid_cnt - v0); end
    checks++; if (err_cnt - e0 != 0) begin failures++; $display("[TB] FAIL nom_errors got=%0d exp=0", err_cnt - e0); end
  endtask

  task automatic test_extremes();
    send_frame(24'h800000, 24'h7FFFFF, 1'b1);
    send_frame(24'h800000, 24'h7FFFFF, 1'b1);
    checks++; if (left_data !== 24'h800000) begin failures++; $display("[TB] FAIL ext_left got=%h exp=800000", left_data); end
    checks++; if (right_data !== 24'h7FFFFF) begin failures++; $display("[TB] FAIL ext_right got=%h exp=7fffff", right_data); end
  endtask

  task automatic test_short_slot();
    int v0, e0;
    send_slot(1'b0, 24'h0F0F0F, 1'b0, 31);
    v0 = valid_cnt; e0 = err_cnt;
    send_slot(1'b1, 24'hF0F0F0, 1'b0, 32);
    checks++; if (err_cnt - e0 != 1) begin failures++; $display("[TB] FAIL short_err got=%0d exp=1", err_cnt - e0); end
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL short_unlock got=%b exp=0", locked); end
    repeat (4) send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0);
    checks++; if (valid_cnt - v0 != 0) begin failures++; $display("[TB] FAIL short_no_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL short_locked_early got=%b exp=0", locked); end
    checks++; if (left_data !== 24'h800000) begin failures++; $display("[TB] FAIL short_hold got=%h exp=800000", left_data); end
    send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b0);
    checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL short_relock got=%b exp=1", locked); end
    checks++; if (valid_cnt - v0 != 1) begin failures++; $display("[TB] FAIL short_valid got=%0d exp=1", valid_cnt - v0); end
    checks++; if (right_data !== 24'hF0F0F0) begin failures++; $display("[TB] FAIL short_right got=%h exp=f0f0f0", right_data); end
  endtask

  task automatic test_timeout();
    int v0, e0, gap;
    send_frame(24'h111111, 24'h222222, 1'b0);
    v0 = valid_cnt; e0 = err_cnt;
    repeat (2000) @(posedge clk);
    @(negedge clk);
    gap = last_err_cyc - last_rise_cyc;
    checks++; if (err_cnt - e0 != 1) begin failures++; $display("[TB] FAIL to_err_count got=%0d exp=1", err_cnt - e0); end
    checks++; if (gap < TIMEOUT || gap > TIMEOUT + SYNC_STAGES + 2) begin
      failures++; $display("[TB] FAIL to_delay got=%0d exp=%0d..%0d", gap, TIMEOUT, TIMEOUT + SYNC_STAGES + 2);
    end
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL to_unlock got=%b exp=0", locked); end
    checks++; if (valid_cnt - v0 != 0) begin failures++; $display("[TB] FAIL to_no_valid got=%0d exp=0", valid_cnt - v0); end
    checks++; if (left_data !== 24'h0F0F0F) begin failures++; $display("[TB] FAIL to_hold_left got=%h exp=0f0f0f", left_data); end
    #3;
    repeat (5) send_frame(24'h135790, 24'h2468AC, 1'b0);
    checks++; if (locked !== 1'b1) begin failures++; $display("[TB] FAIL to_relock got=%b exp=1", locked); end
    checks++; if (left_data !== 24'h135790) begin failures++; $display("[TB] FAIL to_left got=%h exp=135790", left_data); end
  endtask

  task automatic test_reset_mid();
    int v0;
    send_frame(24'hA5A5A5, 24'h5A5A5A, 1'b0);
    send_slot(1'b0, 24'hA5A5A5, 1'b0, 32);
    send_slot(1'b1, 24'h5A5A5A, 1'b0, 10);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (left_data !== 24'h0) begin failures++; $display("[TB] FAIL rst_mid_left got=%h exp=000000", left_data); end
    checks++; if (right_data !== 24'h0) begin failures++; $display("[TB] FAIL rst_mid_right got=%h exp=000000", right_data); end
    checks++; if (locked !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_locked got=%b exp=0", locked); end
    i2s_bclk = 1'b0; i2s_lrck = 1'b0; i2s_sdata = 1'b0; last_bit = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    #3;
    v0 = valid_cnt;
    repeat (5) send_frame(24'h3C3C3C, 24'hC3C3C3, 1'b0);
    checks++; if (locked !== 1'b0 || valid_cnt - v0 != 0) begin
      failures++; $display("[TB] FAIL rst_mid_early got locked=%b valids=%0d exp locked=0 valids=0", locked, valid_cnt - v0);
    end
    send_frame(24'h3C3C3C, 24'hC3C3C3, 1'b0);
    checks++; if (locked !== 1'b1 || valid_cnt - v0 != 1) begin
      failures++; $display("[TB] FAIL rst_mid_relock got locked=%b valids=%0d exp locked=1 valids=1", locked, valid_cnt - v0);
    end
    checks++; if (right_data !== 24'hC3C3C3) begin failures++; $display("[TB] FAIL rst_mid_right_data got=%h exp=c3c3c3", right_data); end
  endtask

  task automatic test_max_rate();
    int v0, e0;
    logic [DATA_W-1:0] pl, pr, cl, cr;
    pl = '0; pr = '0;
    half_lo = 80; half_hi = 80; jitter = 6;
    #($urandom_range(1, 19));
    v0 = valid_cnt; e0 = err_cnt;
    for (int f = 0; f < 40; f++) begin
      cl = DATA_W'($urandom);
      cr = DATA_W'($urandom);
      send_frame(cl, cr, f[0]);
      if (f > 0) begin
        checks++; if (left_data !== pl || right_data !== pr) begin
          failures++; $display("[TB] FAIL max_data frame=%0d got=%h/%h exp=%h/%h", f - 1, left_data, right_data, pl, pr);
        end
      end
      pl = cl; pr = cr;
    end
    checks++; if (err_cnt - e0 != 0) begin failures++; $display("[TB] FAIL max_errors got=%0d exp=0", err_cnt - e0); end
    checks++; if (valid_cnt - v0 != 40) begin failures++; $display("[TB] FAIL max_valids got=%0d exp=40", valid_cnt - v0); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_extremes();
    test_short_slot();
    test_timeout();
    test_reset_mid();
    test_max_rate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
